// File: rtl/fanout_pkg.sv
// Shared constants and mode encoding for the stream fan-out fork.
package fanout_pkg;

  localparam int unsigned FANOUT_MAX_BRANCH = 32;
  localparam int unsigned FANOUT_DATA_WIDTH = 17;

  typedef enum logic {
    FANOUT_LAZY  = 1'b0,
    FANOUT_EAGER = 1'b1
  } fanout_mode_e;

endpackage

// File: rtl/fanout_branch_tracker.sv
// One fan-out branch: remembers whether the current token was already taken (done)
// and gates that branch's valid and its contribution to the upstream ready.
module fanout_branch_tracker
  import fanout_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic cfg_eager,
  input  logic act,
  input  logic in_valid,
  input  logic all_rdy,
  input  logic out_ready,
  input  logic fire,
  input  logic clear,
  input  logic flush,
  output logic out_valid,
  output logic branch_rdy
);

  fanout_mode_e mode;
  logic         done_q, done_d;
  logic         accept;

  always_comb begin
    mode = fanout_mode_e'(cfg_eager);
    if (mode == FANOUT_EAGER) begin
      out_valid  = in_valid & act & ~done_q & ~flush;
      branch_rdy = ~act | done_q | out_ready;
    end else begin
      // Legacy fork: valid waits for every enabled branch to be ready at once.
      out_valid  = in_valid & act & all_rdy & ~flush;
      branch_rdy = ~act | out_ready;
    end
    accept = out_valid & out_ready;
    done_d = done_q | accept;
    if (clear || fire || (mode == FANOUT_LAZY)) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/fanout_eager_fork.sv
// Ready/valid fork broadcasting one upstream token to the enabled branches, with
// eager per-branch acceptance tracking, config shadowing and handshake/stall counters.
module fanout_eager_fork
  import fanout_pkg::*;
#(
  parameter int unsigned NUM_BRANCH      = 7,
  parameter int unsigned DATA_WIDTH      = FANOUT_DATA_WIDTH,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_BRANCH-1:0]      cfg_branch_en,
  input  logic                       cfg_eager,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [NUM_BRANCH-1:0]      out_valid,
  input  logic [NUM_BRANCH-1:0]      out_ready,
  output logic [31:0]                xfer_count,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  fanout_mode_e               mode;
  logic [NUM_BRANCH-1:0]      cfg_en_q, cfg_en_d;
  logic                       cfg_eager_q, cfg_eager_d;
  logic [NUM_BRANCH-1:0]      branch_rdy;
  logic                       all_rdy;
  logic                       cfg_change;
  logic                       clear;
  logic                       fire;
  logic [31:0]                xfer_count_q, xfer_count_d;
  logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  assign out_data    = in_data;
  assign xfer_count  = xfer_count_q;
  assign stall_count = stall_count_q;

  always_comb begin
    mode        = fanout_mode_e'(cfg_eager);
    // Lazy ready is taken straight from the inputs so it never loops through the trackers.
    all_rdy     = &(~cfg_branch_en | out_ready);
    cfg_en_d    = cfg_branch_en;
    cfg_eager_d = cfg_eager;
    cfg_change  = (cfg_branch_en != cfg_en_q) || (cfg_eager != cfg_eager_q);
    clear       = flush | cfg_change;
    in_ready    = ~flush & ((mode == FANOUT_EAGER) ? &branch_rdy : all_rdy);
    fire        = in_valid & in_ready;

    xfer_count_d = xfer_count_q;
    if (fire) begin
      xfer_count_d = xfer_count_q + 32'd1;
    end
    stall_count_d = stall_count_q;
    if (in_valid && !in_ready && (stall_count_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_count_d = stall_count_q + STALL_CNT_WIDTH'(1);
    end
    if (flush) begin
      xfer_count_d  = '0;
      stall_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_en_q      <= '0;
      cfg_eager_q   <= 1'b0;
      xfer_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      cfg_en_q      <= cfg_en_d;
      cfg_eager_q   <= cfg_eager_d;
      xfer_count_q  <= xfer_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  for (genvar gi = 0; gi < NUM_BRANCH; gi++) begin : g_branch
    fanout_branch_tracker u_branch (
      .clk        (clk),
      .reset      (reset),
      .cfg_eager  (cfg_eager),
      .act        (cfg_branch_en[gi]),
      .in_valid   (in_valid),
      .all_rdy    (all_rdy),
      .out_ready  (out_ready[gi]),
      .fire       (fire),
      .clear      (clear),
      .flush      (flush),
      .out_valid  (out_valid[gi]),
      .branch_rdy (branch_rdy[gi])
    );
  end

endmodule

// File: tb/tb_fanout_eager_fork.sv
// Bench for fanout_eager_fork: combinational vector table, then scoreboarded
// multi-cycle sequences (eager, lazy, masking, flush/reset, counter limits).
module tb_fanout_eager_fork;

  localparam int NB = 3;
  localparam int DW = 17;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [NB-1:0] cfg_branch_en;
  logic          cfg_eager;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [NB-1:0] out_valid;
  logic [NB-1:0] out_ready;
  logic [31:0]   xfer_count;
  logic [SW-1:0] stall_count;

  fanout_eager_fork #(
    .NUM_BRANCH      (NB),
    .DATA_WIDTH      (DW),
    .STALL_CNT_WIDTH (SW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .cfg_branch_en (cfg_branch_en),
    .cfg_eager     (cfg_eager),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .xfer_count    (xfer_count),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;

  logic [DW-1:0] sb0[$];
  logic [DW-1:0] sb1[$];
  logic [DW-1:0] sb2[$];

  typedef struct {
    logic          eager;
    logic [NB-1:0] en;
    logic          iv;
    logic [NB-1:0] ordy;
    logic [DW-1:0] data;
    logic          exp_ir;
    logic [NB-1:0] exp_ov;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_push(input logic [NB-1:0] mask, input logic [DW-1:0] d);
    if (mask[0]) sb0.push_back(d);
    if (mask[1]) sb1.push_back(d);
    if (mask[2]) sb2.push_back(d);
  endtask

  task automatic sb_pop(input int b, input logic [DW-1:0] got);
    logic [DW-1:0] e;
    int sz;
    sz = (b == 0) ? sb0.size() : (b == 1) ? sb1.size() : sb2.size();
    if (sz == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_accept branch %0d: got %0h expected none", b, got);
    end else begin
      case (b)
        0:       e = sb0.pop_front();
        1:       e = sb1.pop_front();
        default: e = sb2.pop_front();
      endcase
      chk($sformatf("branch%0d_data", b), 32'(got), 32'(e));
    end
  endtask

  // Accepts are sampled on the falling edge, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      for (int b = 0; b < NB; b++) begin
        if (out_valid[b] && out_ready[b]) sb_pop(b, out_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
  endtask

  task automatic chk_hs(input string name, input logic exp_ir, input logic [NB-1:0] exp_ov);
    chk({name, "_in_ready"}, 32'(in_ready), 32'(exp_ir));
    chk({name, "_out_valid"}, 32'(out_valid), 32'(exp_ov));
  endtask

  logic [NB-1:0] stag_rdy[6];
  logic [NB-1:0] stag_ov[6];

  initial begin
    //           eager en      iv    ordy    data      ir    ov
    vecs[0]  = '{1'b1, 3'b111, 1'b1, 3'b111, 17'h0a5, 1'b1, 3'b111};
    vecs[1]  = '{1'b1, 3'b111, 1'b1, 3'b101, 17'h1ff, 1'b0, 3'b111};
    vecs[2]  = '{1'b1, 3'b010, 1'b1, 3'b101, 17'h003, 1'b0, 3'b010};
    vecs[3]  = '{1'b1, 3'b010, 1'b1, 3'b010, 17'h10f, 1'b1, 3'b010};
    vecs[4]  = '{1'b1, 3'b000, 1'b1, 3'b000, 17'h055, 1'b1, 3'b000};
    vecs[5]  = '{1'b0, 3'b111, 1'b1, 3'b111, 17'h0f0, 1'b1, 3'b111};
    vecs[6]  = '{1'b0, 3'b111, 1'b1, 3'b011, 17'h123, 1'b0, 3'b000};
    vecs[7]  = '{1'b0, 3'b101, 1'b1, 3'b101, 17'h1aa, 1'b1, 3'b101};
    vecs[8]  = '{1'b0, 3'b000, 1'b1, 3'b000, 17'h077, 1'b1, 3'b000};
    vecs[9]  = '{1'b1, 3'b111, 1'b0, 3'b000, 17'h000, 1'b0, 3'b000};
    vecs[10] = '{1'b0, 3'b110, 1'b0, 3'b110, 17'h011, 1'b1, 3'b000};

    stag_rdy[0] = 3'b001; stag_rdy[1] = 3'b001; stag_rdy[2] = 3'b011;
    stag_rdy[3] = 3'b011; stag_rdy[4] = 3'b011; stag_rdy[5] = 3'b111;
    stag_ov[0]  = 3'b111; stag_ov[1]  = 3'b110; stag_ov[2]  = 3'b110;
    stag_ov[3]  = 3'b100; stag_ov[4]  = 3'b100; stag_ov[5]  = 3'b100;

    reset = 1'b1; flush = 1'b0; cfg_eager = 1'b1; cfg_branch_en = 3'b111;
    in_data = '0; in_valid = 1'b0; out_ready = '0;
    #1;
    chk_hs("reset", 1'b0, 3'b000);
    chk("reset_xfer", xfer_count, 32'd0);
    chk("reset_stall", 32'(stall_count), 32'd0);
    step();
    reset = 1'b0;

    // Combinational vectors, each from a flushed (all WAIT) state.
    for (int i = 0; i < 11; i++) begin
      do_flush();
      cfg_eager = vecs[i].eager; cfg_branch_en = vecs[i].en;
      in_valid = vecs[i].iv; out_ready = vecs[i].ordy; in_data = vecs[i].data;
      @(negedge clk);
      chk_hs($sformatf("vec%0d", i), vecs[i].exp_ir, vecs[i].exp_ov);
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].data));
      step();
    end
    do_flush();
    mon_en = 1'b1;

    // Eager, all ready: one fire per cycle.
    cfg_eager = 1'b1; cfg_branch_en = 3'b111; out_ready = 3'b111;
    do_flush();
    for (int k = 0; k < 4; k++) begin
      in_data = 17'h10 + 17'(k); in_valid = 1'b1;
      sb_push(3'b111, in_data);
      @(negedge clk);
      chk($sformatf("allrdy_fire%0d", k), 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("allrdy_xfer", xfer_count, 32'd4);

    // Eager, staggered readies.
    out_ready = '0;
    do_flush();
    in_data = 17'h20; in_valid = 1'b1; sb_push(3'b111, in_data);
    for (int c = 0; c < 6; c++) begin
      out_ready = stag_rdy[c];
      @(negedge clk);
      chk_hs($sformatf("stag_c%0d", c), (c == 5), stag_ov[c]);
      step();
    end
    in_valid = 1'b0; out_ready = '0;
    @(negedge clk);
    chk("stag_stall", 32'(stall_count), 32'd5);
    chk("stag_xfer", xfer_count, 32'd1);

    // Lazy, same stimulus: nothing moves until every branch is ready.
    cfg_eager = 1'b0;
    do_flush();
    in_data = 17'h30; in_valid = 1'b1; sb_push(3'b111, in_data);
    for (int c = 0; c < 6; c++) begin
      out_ready = stag_rdy[c];
      @(negedge clk);
      chk_hs($sformatf("lazy_c%0d", c), (c == 5), (c == 5) ? 3'b111 : 3'b000);
      step();
    end
    in_valid = 1'b0; out_ready = '0;
    @(negedge clk);
    chk("lazy_stall", 32'(stall_count), 32'd5);

    // Masking: only branch 1 is routed.
    cfg_eager = 1'b1; cfg_branch_en = 3'b010;
    do_flush();
    in_data = 17'h40; in_valid = 1'b1; sb_push(3'b010, in_data);
    out_ready = 3'b101;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_hs($sformatf("mask_c%0d", c), 1'b0, 3'b010);
      step();
    end
    out_ready = 3'b111;
    @(negedge clk);
    chk_hs("mask_go", 1'b1, 3'b010);
    step();
    in_valid = 1'b0; cfg_branch_en = 3'b000;
    step();
    in_data = 17'h41; in_valid = 1'b1; out_ready = 3'b000;
    @(negedge clk);
    chk_hs("drop", 1'b1, 3'b000);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("drop_xfer", xfer_count, 32'd2);

    // Flush while branch 0 is SENT: token is offered to branch 0 again.
    cfg_branch_en = 3'b111; out_ready = '0;
    do_flush();
    in_data = 17'h50; in_valid = 1'b1; sb_push(3'b111, in_data); sb_push(3'b001, in_data);
    out_ready = 3'b001;
    step();
    out_ready = 3'b000;
    @(negedge clk);
    chk_hs("sent", 1'b0, 3'b110);
    step();
    flush = 1'b1;
    @(negedge clk);
    chk_hs("flush", 1'b0, 3'b000);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk_hs("post_flush", 1'b0, 3'b111);
    chk("post_flush_stall", 32'(stall_count), 32'd0);
    chk("post_flush_xfer", xfer_count, 32'd0);
    step();
    out_ready = 3'b111;
    step();
    in_valid = 1'b0; out_ready = '0;
    @(negedge clk);
    chk("flush_fire_xfer", xfer_count, 32'd1);

    // Async reset mid-token.
    in_data = 17'h51; in_valid = 1'b1; sb_push(3'b111, in_data); sb_push(3'b001, in_data);
    out_ready = 3'b001;
    step();
    out_ready = 3'b000;
    @(negedge clk);
    chk_hs("pre_reset", 1'b0, 3'b110);
    #1;
    reset = 1'b1;
    #1;
    chk_hs("in_reset", 1'b0, 3'b111);
    chk("in_reset_xfer", xfer_count, 32'd0);
    chk("in_reset_stall", 32'(stall_count), 32'd0);
    step();
    reset = 1'b0; out_ready = 3'b111;
    @(negedge clk);
    chk_hs("post_reset", 1'b1, 3'b111);
    step();
    in_valid = 1'b0; out_ready = '0;
    @(negedge clk);
    chk("post_reset_xfer", xfer_count, 32'd1);

    // Counter limits.
    do_flush();
    in_data = 17'h60; in_valid = 1'b1; sb_push(3'b111, in_data);
    for (int c = 0; c < 20; c++) step();
    @(negedge clk);
    chk("stall_sat", 32'(stall_count), 32'hf);
    step();
    out_ready = 3'b111;
    step();
    in_valid = 1'b0;
    force dut.xfer_count_q = 32'hffff_ffff;
    #1;
    release dut.xfer_count_q;
    @(negedge clk);
    chk("xfer_max", xfer_count, 32'hffff_ffff);
    step();
    in_data = 17'h61; in_valid = 1'b1; sb_push(3'b111, in_data);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("xfer_wrap", xfer_count, 32'd0);

    step();
    mon_en = 1'b0;
    chk("sb0_empty", 32'(sb0.size()), 32'd0);
    chk("sb1_empty", 32'(sb1.size()), 32'd0);
    chk("sb2_empty", 32'(sb2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
